// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control pipeline.
// Holds the opcode and funct encodings of the supported instructions, the
// result-select encoding, the "operand never read" Tuse value, and the
// per-stage entry that travels down the pipe behind each instruction.
package mips_ctrl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    // Which value the W stage writes back
    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_MEM  = 2'd1,
        RES_PC8  = 2'd2,
        RES_HILO = 2'd3
    } res_sel_e;

    // Tuse value for an operand the D instruction never reads
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Write-back control carried by every pipeline stage
    typedef struct packed {
        logic       regwrite;
        logic [4:0] waddr;
        res_sel_e   ressel;
        logic [1:0] tnew;
    } stage_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational decoder for the D-stage instruction.
// Ports:
//   instr    in   32  instruction to decode
//   entry    out  stage_t  write-back control for the stage-0 entry
//   tuse_rs  out  2   cycles until rs is consumed (3 = never)
//   tuse_rt  out  2   cycles until rt is consumed (3 = never)
// Unsupported encodings decode as a NOP (no write, operands never used).
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output stage_t      entry,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic       writes;
    logic [4:0] dest;
    res_sel_e   rsel;
    logic [1:0] tnew;
    logic       unused_bits;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign rt_f        = instr[20:16];
    assign rd_f        = instr[15:11];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        writes  = 1'b0;
        dest    = 5'd0;
        rsel    = RES_ALU;
        tnew    = 2'd0;
        tuse_rs = TUSE_NONE;
        tuse_rt = TUSE_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLLV, F_SRLV, F_SRAV: begin
                        writes  = 1'b1;
                        dest    = rd_f;
                        tnew    = 2'd1;
                        tuse_rs = 2'd1;
                        tuse_rt = 2'd1;
                    end
                    // shift-immediate: rs field is not a register operand
                    F_SLL, F_SRL, F_SRA: begin
                        writes  = 1'b1;
                        dest    = rd_f;
                        tnew    = 2'd1;
                        tuse_rt = 2'd1;
                    end
                    F_JR: begin
                        tuse_rs = 2'd0;
                    end
                    F_JALR: begin
                        writes  = 1'b1;
                        dest    = rd_f;
                        rsel    = RES_PC8;
                        tuse_rs = 2'd0;
                    end
                    F_MFHI, F_MFLO: begin
                        writes = 1'b1;
                        dest   = rd_f;
                        rsel   = RES_HILO;
                        tnew   = 2'd1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                writes  = 1'b1;
                dest    = rt_f;
                tnew    = 2'd1;
                tuse_rs = 2'd1;
            end
            OP_LUI: begin
                writes = 1'b1;
                dest   = rt_f;
                tnew   = 2'd1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                writes  = 1'b1;
                dest    = rt_f;
                rsel    = RES_MEM;
                tnew    = 2'd2;
                tuse_rs = 2'd1;
            end
            OP_SB, OP_SH, OP_SW: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd2;
            end
            OP_BEQ: begin
                tuse_rs = 2'd0;
                tuse_rt = 2'd0;
            end
            OP_JAL: begin
                writes = 1'b1;
                dest   = 5'd31;
                rsel   = RES_PC8;
            end
            default: ;
        endcase
    end

    // A write to $0 is not a write: the whole entry collapses to a non-writer
    // so it can never match an operand or hold a stale Tnew.
    always_comb begin
        entry = '0;
        if (writes && (dest != 5'd0)) begin
            entry.regwrite = 1'b1;
            entry.waddr    = dest;
            entry.ressel   = rsel;
            entry.tnew     = tnew;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: decodes the D instruction once and carries its write-back
// control through STAGES registered stages (0 = E ... STAGES-1 = W), then
// derives the stall request and forwarding selects from that in-flight state.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   instr_d/valid_d instruction in D and its valid flag (0 = bubble)
//   flush_e         force a bubble into stage 0
//   stall_req       D must hold
//   fwd_rs_sel/rt   0 = register file, k+1 = forward from stage k
//   regwrite_s, waddr_s, ressel_s, tnew_s  per-stage fields, stage k in slice k
module ctrl_pipe_hazard
    import mips_ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int SEL_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr_d,
    input  logic                  valid_d,
    input  logic                  flush_e,
    output logic                  stall_req,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic [STAGES-1:0]     regwrite_s,
    output logic [5*STAGES-1:0]   waddr_s,
    output logic [2*STAGES-1:0]   ressel_s,
    output logic [2*STAGES-1:0]   tnew_s
);

    stage_t     dec_entry;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    stage_t     stage_d [STAGES];
    stage_t     stage_q [STAGES];

    assign rs_addr = instr_d[25:21];
    assign rt_addr = instr_d[20:16];

    ctrl_decode u_decode (
        .instr   (instr_d),
        .entry   (dec_entry),
        .tuse_rs (tuse_rs),
        .tuse_rt (tuse_rt)
    );

    // Stall and flush together still insert exactly one bubble.
    always_comb begin
        stage_d[0] = (stall_req || flush_e || !valid_d) ? '0 : dec_entry;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
            if (stage_q[k-1].tnew != 2'd0) begin
                stage_d[k].tnew = stage_q[k-1].tnew - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Scan oldest to youngest so the youngest matching stage sets the select
    // last; any match whose result is not ready in time raises the stall.
    always_comb begin
        stall_req  = 1'b0;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (stage_q[k].regwrite && (stage_q[k].waddr == rs_addr) && (rs_addr != 5'd0)) begin
                fwd_rs_sel = SEL_W'(k + 1);
                if (stage_q[k].tnew > tuse_rs) begin
                    stall_req = 1'b1;
                end
            end
            if (stage_q[k].regwrite && (stage_q[k].waddr == rt_addr) && (rt_addr != 5'd0)) begin
                fwd_rt_sel = SEL_W'(k + 1);
                if (stage_q[k].tnew > tuse_rt) begin
                    stall_req = 1'b1;
                end
            end
        end
    end

    always_comb begin
        regwrite_s = '0;
        waddr_s    = '0;
        ressel_s   = '0;
        tnew_s     = '0;
        for (int k = 0; k < STAGES; k++) begin
            regwrite_s[k]      = stage_q[k].regwrite;
            waddr_s[5*k +: 5]  = stage_q[k].waddr;
            ressel_s[2*k +: 2] = stage_q[k].ressel;
            tnew_s[2*k +: 2]   = stage_q[k].tnew;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed hazard scenarios followed by random
// instruction streams, all checked against a behavioural pipeline model.
module tb_ctrl_pipe_hazard;

    localparam int STAGES = 3;
    localparam int SEL_W  = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         instr_d;
    logic                valid_d;
    logic                flush_e;
    logic                stall_req;
    logic [SEL_W-1:0]    fwd_rs_sel;
    logic [SEL_W-1:0]    fwd_rt_sel;
    logic [STAGES-1:0]   regwrite_s;
    logic [5*STAGES-1:0] waddr_s;
    logic [2*STAGES-1:0] ressel_s;
    logic [2*STAGES-1:0] tnew_s;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit rw;
        int waddr;
        int ressel;
        int tnew;
    } ent_t;

    ent_t pipe [STAGES];

    logic [5:0] functList [16] = '{6'h21, 6'h23, 6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h04,
                                   6'h24, 6'h2a, 6'h08, 6'h09, 6'h10, 6'h12, 6'h27, 6'h3f};
    logic [5:0] opList [20] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b,
                                6'h04, 6'h02, 6'h03, 6'h3f};
    int regPool [5] = '{0, 1, 2, 3, 31};

    always #5 clk = ~clk;

    ctrl_pipe_hazard #(.STAGES(STAGES), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_d    (instr_d),
        .valid_d    (valid_d),
        .flush_e    (flush_e),
        .stall_req  (stall_req),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .regwrite_s (regwrite_s),
        .waddr_s    (waddr_s),
        .ressel_s   (ressel_s),
        .tnew_s     (tnew_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction classes straight from the ISA table: destination, result
    // kind, Tnew on entry and per-operand Tuse.
    function automatic void modelDecode(input logic [31:0] ins, output ent_t e,
                                        output int tuRs, output int tuRt);
        int op   = int'(ins[31:26]);
        int fn   = int'(ins[5:0]);
        int rt   = int'(ins[20:16]);
        int rd   = int'(ins[15:11]);
        bit wr   = 0;
        int dest = 0;
        int rsel = 0;
        int tn   = 0;
        tuRs = 3;
        tuRt = 3;
        if (op == 0) begin
            if (fn inside {'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h04, 'h06, 'h07}) begin
                wr = 1; dest = rd; tn = 1; tuRs = 1; tuRt = 1;
            end else if (fn inside {'h00, 'h02, 'h03}) begin
                wr = 1; dest = rd; tn = 1; tuRt = 1;
            end else if (fn == 'h08) begin
                tuRs = 0;
            end else if (fn == 'h09) begin
                wr = 1; dest = rd; rsel = 2; tn = 0; tuRs = 0;
            end else if (fn inside {'h10, 'h12}) begin
                wr = 1; dest = rd; rsel = 3; tn = 1;
            end
        end else if (op inside {'h08, 'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e}) begin
            wr = 1; dest = rt; tn = 1; tuRs = 1;
        end else if (op == 'h0f) begin
            wr = 1; dest = rt; tn = 1;
        end else if (op inside {'h20, 'h21, 'h23, 'h24, 'h25}) begin
            wr = 1; dest = rt; rsel = 1; tn = 2; tuRs = 1;
        end else if (op inside {'h28, 'h29, 'h2b}) begin
            tuRs = 1; tuRt = 2;
        end else if (op == 'h04) begin
            tuRs = 0; tuRt = 0;
        end else if (op == 'h03) begin
            wr = 1; dest = 31; rsel = 2; tn = 0;
        end
        if (wr && dest != 0) e = '{rw: 1, waddr: dest, ressel: rsel, tnew: tn};
        else                 e = '{rw: 0, waddr: 0, ressel: 0, tnew: 0};
    endfunction

    function automatic void modelHazard(output bit st, output int selRs, output int selRt);
        ent_t e;
        int tuRs, tuRt;
        int rs = int'(instr_d[25:21]);
        int rt = int'(instr_d[20:16]);
        modelDecode(instr_d, e, tuRs, tuRt);
        st = 0; selRs = 0; selRt = 0;
        for (int k = 0; k < STAGES; k++) begin
            if (pipe[k].rw && rs != 0 && pipe[k].waddr == rs) begin
                if (selRs == 0) selRs = k + 1;
                if (pipe[k].tnew > tuRs) st = 1;
            end
            if (pipe[k].rw && rt != 0 && pipe[k].waddr == rt) begin
                if (selRt == 0) selRt = k + 1;
                if (pipe[k].tnew > tuRt) st = 1;
            end
        end
    endfunction

    task automatic clearModel();
        for (int k = 0; k < STAGES; k++) pipe[k] = '{rw: 0, waddr: 0, ressel: 0, tnew: 0};
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic f);
        instr_d = ins;
        valid_d = v;
        flush_e = f;
        #3;
    endtask

    task automatic checkAll(input string tag);
        bit st;
        int sRs, sRt;
        logic [31:0] eRw, eWa, eRs, eTn;
        modelHazard(st, sRs, sRt);
        eRw = '0; eWa = '0; eRs = '0; eTn = '0;
        for (int k = 0; k < STAGES; k++) begin
            eRw[k]        = pipe[k].rw;
            eWa[5*k +: 5] = 5'(pipe[k].waddr);
            eRs[2*k +: 2] = 2'(pipe[k].ressel);
            eTn[2*k +: 2] = 2'(pipe[k].tnew);
        end
        checkOutput({tag, ".stall"}, 32'(stall_req), 32'(st));
        checkOutput({tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(sRs));
        checkOutput({tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(sRt));
        checkOutput({tag, ".regwrite"}, 32'(regwrite_s), eRw);
        checkOutput({tag, ".waddr"}, 32'(waddr_s), eWa);
        checkOutput({tag, ".ressel"}, 32'(ressel_s), eRs);
        checkOutput({tag, ".tnew"}, 32'(tnew_s), eTn);
    endtask

    // Clock edge: every entry moves one stage older and ages by a cycle; the
    // D instruction enters only if it is valid, not stalled and not flushed.
    task automatic advance();
        bit st;
        int a, b, tr, tt;
        ent_t e;
        modelHazard(st, a, b);
        modelDecode(instr_d, e, tr, tt);
        @(posedge clk);
        for (int k = STAGES - 1; k >= 1; k--) begin
            pipe[k] = pipe[k-1];
            if (pipe[k].tnew > 0) pipe[k].tnew = pipe[k].tnew - 1;
        end
        if (st || flush_e || !valid_d) pipe[0] = '{rw: 0, waddr: 0, ressel: 0, tnew: 0};
        else                           pipe[0] = e;
        #1;
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic f, input string tag);
        applyStimulus(ins, v, f);
        checkAll(tag);
        advance();
    endtask

    task automatic drain();
        for (int i = 0; i < STAGES; i++) step(32'h0, 1'b1, 1'b0, "drain");
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0] rs = 5'(regPool[$urandom_range(0, 4)]);
        logic [4:0] rt = 5'(regPool[$urandom_range(0, 4)]);
        logic [4:0] rd = 5'(regPool[$urandom_range(0, 4)]);
        if ($urandom_range(0, 1) == 0)
            return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), functList[$urandom_range(0, 15)]};
        return {opList[$urandom_range(0, 19)], rs, rt, 16'($urandom_range(0, 65535))};
    endfunction

    initial begin
        logic [31:0] cur;
        bit st;
        int a, b;
        reset   = 1'b1;
        instr_d = 32'h0;
        valid_d = 1'b0;
        flush_e = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.stall", 32'(stall_req), 32'd0);
        checkOutput("reset.regwrite", 32'(regwrite_s), 32'd0);
        #2;
        reset = 1'b0;

        // load-use: one stall, then forward from stage 1
        step(32'h8C280000, 1'b1, 1'b0, "lw");
        applyStimulus(32'h01024821, 1'b1, 1'b0);
        checkAll("lwuse0");
        checkOutput("lwuse.stall", 32'(stall_req), 32'd1);
        advance();
        applyStimulus(32'h01024821, 1'b1, 1'b0);
        checkAll("lwuse1");
        checkOutput("lwuse.nostall", 32'(stall_req), 32'd0);
        checkOutput("lwuse.fwd_rs", 32'(fwd_rs_sel), 32'd2);
        checkOutput("lwuse.tnew1", 32'(tnew_s[3:2]), 32'd1);
        checkOutput("lwuse.bubble0", 32'(regwrite_s[0]), 32'd0);
        advance();
        drain();

        // ALU result consumed by a branch
        step(32'h00221821, 1'b1, 1'b0, "addu3");
        applyStimulus(32'h10600000, 1'b1, 1'b0);
        checkAll("beq0");
        checkOutput("beq.stall", 32'(stall_req), 32'd1);
        advance();
        applyStimulus(32'h10600000, 1'b1, 1'b0);
        checkAll("beq1");
        checkOutput("beq.fwd_rs", 32'(fwd_rs_sel), 32'd2);
        checkOutput("beq.fwd_rt", 32'(fwd_rt_sel), 32'd0);
        advance();
        drain();

        // jal then jr $31
        step(32'h0C000010, 1'b1, 1'b0, "jal");
        applyStimulus(32'h03E00008, 1'b1, 1'b0);
        checkAll("jr");
        checkOutput("jr.stall", 32'(stall_req), 32'd0);
        checkOutput("jr.fwd_rs", 32'(fwd_rs_sel), 32'd1);
        checkOutput("jr.waddr0", 32'(waddr_s[4:0]), 32'd31);
        checkOutput("jr.ressel0", 32'(ressel_s[1:0]), 32'd2);
        advance();
        drain();

        // two writers of $5: the youngest wins
        step(32'h24050001, 1'b1, 1'b0, "addiu_a");
        step(32'h24050001, 1'b1, 1'b0, "addiu_b");
        applyStimulus(32'hAC050000, 1'b1, 1'b0);
        checkAll("sw");
        checkOutput("sw.fwd_rt", 32'(fwd_rt_sel), 32'd1);
        checkOutput("sw.stall", 32'(stall_req), 32'd0);
        advance();
        drain();

        // flush during a stall: a single bubble, older entry shifts and ages
        step(32'h8C280000, 1'b1, 1'b0, "lw_f");
        applyStimulus(32'h01024821, 1'b1, 1'b1);
        checkAll("flush0");
        checkOutput("flush.stall", 32'(stall_req), 32'd1);
        advance();
        applyStimulus(32'h0, 1'b1, 1'b0);
        checkAll("flush1");
        checkOutput("flush.bubble0", 32'(regwrite_s[0]), 32'd0);
        checkOutput("flush.waddr1", 32'(waddr_s[9:5]), 32'd8);
        checkOutput("flush.tnew1", 32'(tnew_s[3:2]), 32'd1);
        advance();

        // reset while stages hold live entries
        step(32'h8C280000, 1'b1, 1'b0, "pre_a");
        step(32'h24050001, 1'b1, 1'b0, "pre_b");
        applyStimulus(32'h00A52821, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midreset.stall", 32'(stall_req), 32'd0);
        checkOutput("midreset.fwd_rs", 32'(fwd_rs_sel), 32'd0);
        checkOutput("midreset.fwd_rt", 32'(fwd_rt_sel), 32'd0);
        checkOutput("midreset.regwrite", 32'(regwrite_s), 32'd0);
        checkOutput("midreset.waddr", 32'(waddr_s), 32'd0);
        checkOutput("midreset.tnew", 32'(tnew_s), 32'd0);
        clearModel();
        #1;
        reset = 1'b0;
        step(32'h0, 1'b1, 1'b0, "post_reset");
        drain();

        // random streams; a stalled instruction usually stays in D
        cur = randInstr();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(cur, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0));
            checkAll("rand");
            modelHazard(st, a, b);
            advance();
            if (!st || $urandom_range(0, 3) == 0) cur = randInstr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
